// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width helpers; the widths depend on the instance parameters, so they are
    // evaluated at elaboration in each module that imports this package.
    function automatic int gid_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int bcnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

    function automatic int wrap_inc(input int idx, input int num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin search: first valid requester at or after start_idx, wrapping.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = gid_w(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GID_W-1:0]   start_idx,
    output logic               found,
    output logic [GID_W-1:0]   pick_idx
);

    always_comb begin : pick_search
        int idx;
        found    = 1'b0;
        pick_idx = '0;
        idx      = int'(start_idx);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[idx[GID_W-1:0]]) begin
                found    = 1'b1;
                pick_idx = idx[GID_W-1:0];
            end
            idx = wrap_inc(idx, NUM_REQ);
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
)(
    input  logic                          w_clk,
    input  logic                          w_reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          w_full,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic                          w_inc,
    output logic [gid_w(NUM_REQ)-1:0]     grant_id,
    output logic                          busy
);

    localparam int GID_W  = gid_w(NUM_REQ);
    localparam int BCNT_W = bcnt_w(MAX_BURST);

    arb_state_t         state_q, state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic               cur_valid;
    logic               xfer;
    logic               burst_end;
    logic               drop_grant;
    logic [GID_W-1:0]   start_idx;
    logic               found;
    logic [GID_W-1:0]   pick_idx;

    assign busy       = (state_q == GRANT);
    assign grant_id   = grant_id_q;
    assign cur_valid  = req_valid[grant_id_q];
    assign xfer       = busy & cur_valid & ~w_full;
    assign w_inc      = xfer;
    assign burst_end  = (burst_cnt_q == BCNT_W'(MAX_BURST - 1));
    assign drop_grant = busy & ((xfer & burst_end) | ~cur_valid);

    // One picker serves both paths: from IDLE the search starts after the
    // last owner, on release it starts after the current owner, so the
    // releasing requester is always considered last.
    assign start_idx = busy ? GID_W'(wrap_inc(int'(grant_id_q), NUM_REQ))
                            : GID_W'(wrap_inc(int'(last_grant_q), NUM_REQ));

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_pick (
        .req_valid (req_valid),
        .start_idx (start_idx),
        .found     (found),
        .pick_idx  (pick_idx)
    );

    always_comb begin
        req_ready = '0;
        w_data    = '0;
        if (xfer) begin
            req_ready[grant_id_q] = 1'b1;
        end
        if (busy) begin
            w_data = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (drop_grant) begin
                    last_grant_d = grant_id_q;
                    if (found) begin
                        grant_id_d  = pick_idx;
                        burst_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter with a behavioural FIFO sink for the end-to-end run.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int DW     = 8;
    localparam int NR     = 4;
    localparam int MB     = 4;
    localparam int FDEPTH = 8;

    logic            w_clk = 1'b0;
    logic            w_reset;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            w_full;
    logic [DW-1:0]   w_data;
    logic            w_inc;
    logic [1:0]      grant_id;
    logic            busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] src_q [NR][$];
    logic [9:0]    exp_q [$];
    logic [DW-1:0] fifo_q [$];
    logic          full_force = 1'b0;
    bit            e2e = 1'b0;
    int            next_seq [NR];
    int            reads = 0;

    fifo_write_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .w_clk     (w_clk),
        .w_reset   (w_reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w_full    (w_full),
        .w_data    (w_data),
        .w_inc     (w_inc),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 w_clk = ~w_clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int id, input logic [DW-1:0] d);
        src_q[id].push_back(d);
    endtask

    task automatic expect_word(input int id, input logic [DW-1:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = (src_q[i].size() > 0);
            req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        w_full = e2e ? (fifo_q.size() >= FDEPTH) : full_force;
    endtask

    task automatic wait_busy(input string name);
        int cyc = 0;
        while (!busy && cyc < 20) begin
            @(negedge w_clk);
            cyc++;
        end
        check_eq(name, 32'(busy), 32'd1);
    endtask

    task automatic wait_writes(input int n, input string name);
        int seen = 0;
        int cyc  = 0;
        while (cyc < 50) begin
            if (w_inc) seen++;
            if (seen == n) break;
            @(negedge w_clk);
            cyc++;
        end
        check_eq(name, 32'(seen), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int  cyc = 0;
        bit  pending = 1'b1;
        while (pending && cyc < 1000) begin
            pending = busy || (e2e && fifo_q.size() > 0);
            for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) pending = 1'b1;
            if (pending) begin
                @(negedge w_clk);
                cyc++;
            end
        end
        check_eq(name, 32'(pending), 32'd0);
        @(negedge w_clk);
    endtask

    // Requester drivers plus behavioural FIFO (write every cycle, read every other cycle).
    initial begin
        logic [NR-1:0] acc;
        logic          wr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        bit            rd_phase;
        int            id;
        rd_phase = 1'b0;
        #1 drive();
        forever begin
            @(negedge w_clk);
            acc = req_ready;
            wr  = w_inc;
            wd  = w_data;
            @(posedge w_clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            if (e2e) begin
                if (wr) fifo_q.push_back(wd);
                rd_phase = ~rd_phase;
                if (rd_phase && fifo_q.size() > 0) begin
                    rd = fifo_q.pop_front();
                    id = int'(rd[6:5]);
                    check_eq("read_order", 32'(rd[4:0]), 32'(next_seq[id]));
                    next_seq[id]++;
                    reads++;
                end
            end
            drive();
        end
    end

    // Scoreboard monitor: every accepted word must match the next expected (grant, data).
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge w_clk);
            if (!w_reset) begin
                if (w_inc) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_write", 32'({grant_id, w_data}), 32'h1_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("write_word", 32'({grant_id, w_data}), 32'(e));
                    end
                    check_eq("ready_onehot", 32'(req_ready), 32'(NR'(1) << grant_id));
                end else begin
                    check_eq("ready_quiet", 32'(req_ready), 32'd0);
                end
                if (!busy) check_eq("idle_outputs", 32'({w_inc, w_data}), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fair_ids [3];
        int run;
        fair_ids = '{0, 1, 3};
        for (int i = 0; i < NR; i++) next_seq[i] = 0;

        // Reset with every requester valid.
        w_reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            send(i, 8'(8'hA0 + i));
            expect_word(i, 8'(8'hA0 + i));
        end
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        check_eq("rst_w_inc", 32'(w_inc), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_w_data", 32'(w_data), 32'd0);
        w_reset = 1'b0;
        @(negedge w_clk);
        check_eq("first_grant_id", 32'(grant_id), 32'd0);
        check_eq("first_busy", 32'(busy), 32'd1);
        check_eq("first_w_inc", 32'(w_inc), 32'd1);
        wait_idle("reset_drain");

        // Fairness: 0, 1, 3 continuously valid, bursts of 4, no idle hand-off.
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 3; j++) send(fair_ids[j], 8'(fair_ids[j]*16 + k));
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 4; k++) expect_word(fair_ids[j], 8'(fair_ids[j]*16 + b*4 + k));
        wait_busy("fair_start");
        run = 0;
        for (int c = 0; c < 24; c++) begin
            if (w_inc) run++;
            @(negedge w_clk);
        end
        check_eq("fair_back_to_back", 32'(run), 32'd24);
        wait_idle("fair_drain");

        // Single requester, 6 words, re-grant at word 4 without a bubble.
        for (int k = 0; k < 6; k++) begin
            send(2, 8'(8'h10 + k));
            expect_word(2, 8'(8'h10 + k));
        end
        wait_busy("single_start");
        for (int c = 0; c < 6; c++) begin
            check_eq("single_w_inc", 32'(w_inc), 32'd1);
            check_eq("single_grant", 32'(grant_id), 32'd2);
            @(negedge w_clk);
        end
        wait_idle("single_drain");

        // Full stall after word 2 of a burst, with a competitor waiting.
        for (int k = 0; k < 6; k++) send(0, 8'(8'h50 + k));
        send(1, 8'h60);
        send(1, 8'h61);
        for (int k = 0; k < 4; k++) expect_word(0, 8'(8'h50 + k));
        expect_word(1, 8'h60);
        expect_word(1, 8'h61);
        expect_word(0, 8'h54);
        expect_word(0, 8'h55);
        wait_busy("stall_start");
        wait_writes(2, "stall_two_words");
        full_force = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge w_clk);
            check_eq("stall_w_inc", 32'(w_inc), 32'd0);
            check_eq("stall_req_ready", 32'(req_ready), 32'd0);
            check_eq("stall_grant", 32'(grant_id), 32'd0);
        end
        full_force = 1'b0;
        wait_idle("stall_drain");

        // Early release: req 1 runs dry after 2 words while req 3 waits.
        send(1, 8'h70);
        send(1, 8'h71);
        for (int k = 0; k < 3; k++) send(3, 8'(8'h90 + k));
        expect_word(1, 8'h70);
        expect_word(1, 8'h71);
        for (int k = 0; k < 3; k++) expect_word(3, 8'(8'h90 + k));
        wait_busy("early_start");
        check_eq("early_first_grant", 32'(grant_id), 32'd1);
        wait_writes(2, "early_two_words");
        @(negedge w_clk);
        check_eq("early_drop_grant", 32'(grant_id), 32'd1);
        check_eq("early_drop_w_inc", 32'(w_inc), 32'd0);
        @(negedge w_clk);
        check_eq("early_new_grant", 32'(grant_id), 32'd3);
        check_eq("early_new_w_inc", 32'(w_inc), 32'd1);
        check_eq("early_new_data", 32'(w_data), 32'h90);
        wait_idle("early_drain");

        // End-to-end: 4 x 32 tagged words into a FIFO drained at half rate.
        e2e = 1'b1;
        for (int i = 0; i < NR; i++)
            for (int s = 0; s < 32; s++) send(i, 8'(i*32 + s));
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < 4; k++) expect_word(i, 8'(i*32 + r*4 + k));
        wait_busy("e2e_start");
        wait_idle("e2e_drain");
        check_eq("e2e_read_count", 32'(reads), 32'd128);
        for (int i = 0; i < NR; i++) check_eq("e2e_per_req_count", 32'(next_seq[i]), 32'd32);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
